// File: rtl/uart_rx_pkg.sv
// UART receive shared definitions: frame-checker state encoding, parity sense
// constants and the legal parameter ranges for the frame checker.
// Latency: n/a (types and constants only). Backpressure: n/a.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Parity sense as carried on PAR_TYP.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DATA_WIDTH_MIN = 5;
    localparam int DATA_WIDTH_MAX = 9;
    localparam int STOP_BITS_MIN  = 1;
    localparam int STOP_BITS_MAX  = 2;

endpackage

// File: rtl/rx_frame_chk_if.sv
// Bundle between the bit sampler / control side (master) and the receive
// frame checker (slave): strobed sampled bits in; data word, pulses, count out.
// Latency: n/a (wires only). Backpressure: none, the checker consumes every strobe.
interface rx_frame_chk_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ERR_CNT_W  = 8
);
    // sampler / control side
    logic                  frm_start;
    logic                  bit_strb;
    logic                  sampled_bit;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  err_clr;
    // checker results
    logic                  busy;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  strt_glitch;
    logic                  par_err;
    logic                  stp_err;
    logic [ERR_CNT_W-1:0]  err_cnt;

    modport master (
        output frm_start, bit_strb, sampled_bit, PAR_EN, PAR_TYP, err_clr,
        input  busy, P_DATA, data_valid, strt_glitch, par_err, stp_err, err_cnt
    );

    modport slave (
        input  frm_start, bit_strb, sampled_bit, PAR_EN, PAR_TYP, err_clr,
        output busy, P_DATA, data_valid, strt_glitch, par_err, stp_err, err_cnt
    );

endinterface

// File: rtl/rx_frame_chk.sv
// UART receive frame checker: deserialises start/data/parity/stop bits LSB-first
// and flags start glitches, parity and stop errors; keeps a saturating error count.
// Latency: every result is registered, one cycle after the strobe that decides it.
// Backpressure: none; one strobe per cycle is accepted, frm_start only in IDLE.
// Ports: CLK, RST (async, active-high); bus = rx_frame_chk_if.slave carrying
//   frm_start/bit_strb/sampled_bit/PAR_EN/PAR_TYP/err_clr in and
//   busy/P_DATA/data_valid/strt_glitch/par_err/stp_err/err_cnt out.
module rx_frame_chk
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int ERR_CNT_W  = 8
) (
    input  logic          CLK,
    input  logic          RST,
    rx_frame_chk_if.slave bus
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    generate
        if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX ||
            STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_param
            $error("rx_frame_chk: DATA_WIDTH must be 5..9 and STOP_BITS 1..2");
        end
    endgenerate

    rx_state_e             state_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_acc_q;     // XOR of data bits seen so far
    logic                  err_flag_q;    // parity or stop error seen in this frame
    logic [CNT_W-1:0]      bit_cnt_q;
    logic                  stop_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  busy_q;
    logic                  data_valid_q;
    logic                  strt_glitch_q;
    logic                  par_err_q;
    logic                  stp_err_q;
    logic [ERR_CNT_W-1:0]  err_cnt_q;
    logic [ERR_CNT_W-1:0]  err_cnt_d;

    logic par_exp;
    logic frame_bad;

    assign par_exp = (par_typ_q == PAR_ODD) ? ~par_acc_q : par_acc_q;

    // A frame is counted as errored exactly once: either at a glitched start
    // bit or at its final stop strobe (earlier errors are folded into err_flag_q,
    // a low final stop bit is caught directly).
    always_comb begin
        frame_bad = 1'b0;
        if (bus.bit_strb) begin
            if (state_q == START && bus.sampled_bit) begin
                frame_bad = 1'b1;
            end
            if (state_q == STOP && stop_cnt_q == LAST_STOP &&
                (err_flag_q || !bus.sampled_bit)) begin
                frame_bad = 1'b1;
            end
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (bus.err_clr) begin
            err_cnt_d = '0;
        end else if (frame_bad && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= IDLE;
            par_en_q      <= 1'b0;
            par_typ_q     <= 1'b0;
            par_acc_q     <= 1'b0;
            err_flag_q    <= 1'b0;
            bit_cnt_q     <= '0;
            stop_cnt_q    <= 1'b0;
            shift_q       <= '0;
            p_data_q      <= '0;
            busy_q        <= 1'b0;
            data_valid_q  <= 1'b0;
            strt_glitch_q <= 1'b0;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;
        end else begin
            data_valid_q  <= 1'b0;
            strt_glitch_q <= 1'b0;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    // A strobe in IDLE is stale sampler output and is dropped.
                    if (bus.frm_start) begin
                        state_q    <= START;
                        par_en_q   <= bus.PAR_EN;
                        par_typ_q  <= bus.PAR_TYP;
                        par_acc_q  <= 1'b0;
                        err_flag_q <= 1'b0;
                        bit_cnt_q  <= '0;
                        stop_cnt_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end

                START: begin
                    if (bus.bit_strb) begin
                        if (bus.sampled_bit) begin
                            strt_glitch_q <= 1'b1;
                            busy_q        <= 1'b0;
                            state_q       <= IDLE;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (bus.bit_strb) begin
                        // LSB arrives first, so shifting in at the MSB leaves
                        // it at bit 0 after DATA_WIDTH strobes.
                        shift_q   <= {bus.sampled_bit, shift_q[DATA_WIDTH-1:1]};
                        par_acc_q <= par_acc_q ^ bus.sampled_bit;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                end

                PARITY: begin
                    if (bus.bit_strb) begin
                        if (bus.sampled_bit != par_exp) begin
                            par_err_q  <= 1'b1;
                            err_flag_q <= 1'b1;
                        end
                        state_q <= STOP;
                    end
                end

                STOP: begin
                    if (bus.bit_strb) begin
                        if (!bus.sampled_bit) begin
                            stp_err_q  <= 1'b1;
                            err_flag_q <= 1'b1;
                        end
                        if (stop_cnt_q == LAST_STOP) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            if (!err_flag_q && bus.sampled_bit) begin
                                p_data_q     <= shift_q;
                                data_valid_q <= 1'b1;
                            end
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.P_DATA      = p_data_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.strt_glitch = strt_glitch_q;
    assign bus.par_err     = par_err_q;
    assign bus.stp_err     = stp_err_q;
    assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_rx_frame_chk.sv
// Directed bench for rx_frame_chk: three configurations (8-1, 8-2 stop, 7-bit
// with 2-bit error counter) share one stimulus bus, each with its own reset.
// Each scenario checks only the instance it targets, after resetting it.
module tb_rx_frame_chk;
    import uart_rx_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;

    logic frm_start   = 1'b0;
    logic bit_strb    = 1'b0;
    logic sampled_bit = 1'b0;
    logic par_en      = 1'b0;
    logic par_typ     = 1'b0;
    logic err_clr     = 1'b0;

    rx_frame_chk_if #(.DATA_WIDTH(8), .ERR_CNT_W(8)) if_a ();
    rx_frame_chk_if #(.DATA_WIDTH(8), .ERR_CNT_W(8)) if_b ();
    rx_frame_chk_if #(.DATA_WIDTH(7), .ERR_CNT_W(2)) if_c ();

    assign if_a.frm_start = frm_start;   assign if_b.frm_start = frm_start;   assign if_c.frm_start = frm_start;
    assign if_a.bit_strb = bit_strb;     assign if_b.bit_strb = bit_strb;     assign if_c.bit_strb = bit_strb;
    assign if_a.sampled_bit = sampled_bit; assign if_b.sampled_bit = sampled_bit; assign if_c.sampled_bit = sampled_bit;
    assign if_a.PAR_EN = par_en;         assign if_b.PAR_EN = par_en;         assign if_c.PAR_EN = par_en;
    assign if_a.PAR_TYP = par_typ;       assign if_b.PAR_TYP = par_typ;       assign if_c.PAR_TYP = par_typ;
    assign if_a.err_clr = err_clr;       assign if_b.err_clr = err_clr;       assign if_c.err_clr = err_clr;

    rx_frame_chk #(.DATA_WIDTH(8), .STOP_BITS(1), .ERR_CNT_W(8)) dut_a (.CLK(clk), .RST(rst_a), .bus(if_a.slave));
    rx_frame_chk #(.DATA_WIDTH(8), .STOP_BITS(2), .ERR_CNT_W(8)) dut_b (.CLK(clk), .RST(rst_b), .bus(if_b.slave));
    rx_frame_chk #(.DATA_WIDTH(7), .STOP_BITS(1), .ERR_CNT_W(2)) dut_c (.CLK(clk), .RST(rst_c), .bus(if_c.slave));

    // Pulse-cycle counters (sampled mid-cycle).
    int dv_a = 0, pe_a = 0, se_a = 0, sg_a = 0;
    int dv_b = 0, se_b = 0;
    int dv_c = 0, pe_c = 0;

    always @(negedge clk) begin
        if (if_a.data_valid)  dv_a <= dv_a + 1;
        if (if_a.par_err)     pe_a <= pe_a + 1;
        if (if_a.stp_err)     se_a <= se_a + 1;
        if (if_a.strt_glitch) sg_a <= sg_a + 1;
        if (if_b.data_valid)  dv_b <= dv_b + 1;
        if (if_b.stp_err)     se_b <= se_b + 1;
        if (if_c.data_valid)  dv_c <= dv_c + 1;
        if (if_c.par_err)     pe_c <= pe_c + 1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // PAR_EN/PAR_TYP are inverted after the start pulse to show they are latched.
    task automatic start_frame(input logic pen, input logic ptyp);
        frm_start = 1'b1;
        par_en    = pen;
        par_typ   = ptyp;
        tick();
        frm_start = 1'b0;
        par_en    = ~pen;
        par_typ   = ~ptyp;
    endtask

    task automatic strobe(input logic b);
        bit_strb    = 1'b1;
        sampled_bit = b;
        tick();
        bit_strb    = 1'b0;
    endtask

    // Full frame with strobes on consecutive cycles; sv[0] is the first stop bit.
    task automatic send_frame(input logic [8:0] d, input int nb, input logic pen,
                              input logic ptyp, input logic pbit, input int ns,
                              input logic [1:0] sv);
        start_frame(pen, ptyp);
        strobe(1'b0);
        for (int i = 0; i < nb; i++) strobe(d[i]);
        if (pen) strobe(pbit);
        for (int i = 0; i < ns; i++) strobe(sv[i]);
    endtask

    initial begin
        int s_dv, s_pe, s_se, s_sg;
        logic [8:0] d55;

        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;

        // Reset state
        chk("rst_busy",   if_a.busy, 0);
        chk("rst_pdata",  if_a.P_DATA, 0);
        chk("rst_dv",     if_a.data_valid, 0);
        chk("rst_errcnt", if_a.err_cnt, 0);

        // 8N1, 0xA5
        s_dv = dv_a; s_pe = pe_a; s_se = se_a; s_sg = sg_a;
        send_frame(9'h0A5, 8, 1'b0, PAR_EVEN, 1'b0, 1, 2'b01);
        chk("8n1_dv_now",  if_a.data_valid, 1);
        chk("8n1_pdata",   if_a.P_DATA, 8'hA5);
        chk("8n1_busy_lo", if_a.busy, 0);
        tick();
        chk("8n1_dv_one_cycle", if_a.data_valid, 0);
        chk("8n1_dv_cnt",  dv_a - s_dv, 1);
        chk("8n1_errpulses", (pe_a - s_pe) + (se_a - s_se) + (sg_a - s_sg), 0);
        chk("8n1_errcnt",  if_a.err_cnt, 0);

        // 8E1, 0x07 with wrong parity bit 0 (expected 1)
        s_dv = dv_a; s_pe = pe_a; s_se = se_a;
        send_frame(9'h007, 8, 1'b1, PAR_EVEN, 1'b0, 1, 2'b01);
        tick();
        chk("8e1_par_err_cnt", pe_a - s_pe, 1);
        chk("8e1_stp_err_cnt", se_a - s_se, 0);
        chk("8e1_dv_cnt",      dv_a - s_dv, 0);
        chk("8e1_pdata_held",  if_a.P_DATA, 8'hA5);
        chk("8e1_errcnt",      if_a.err_cnt, 1);

        // Start glitch, then a back-to-back good frame whose frm_start
        // coincides with a stray strobe (ignored in IDLE).
        s_dv = dv_a; s_sg = sg_a;
        start_frame(1'b0, PAR_EVEN);
        chk("gl_busy_up", if_a.busy, 1);
        strobe(1'b1);
        chk("gl_pulse_now", if_a.strt_glitch, 1);
        chk("gl_busy_down", if_a.busy, 0);
        chk("gl_errcnt", if_a.err_cnt, 2);
        bit_strb    = 1'b1;
        sampled_bit = 1'b1;
        send_frame(9'h03C, 8, 1'b0, PAR_EVEN, 1'b0, 1, 2'b01);
        chk("gl_next_dv_now", if_a.data_valid, 1);
        chk("gl_next_pdata",  if_a.P_DATA, 8'h3C);
        tick();
        chk("gl_dv_cnt", dv_a - s_dv, 1);
        chk("gl_sg_cnt", sg_a - s_sg, 1);
        chk("gl_errcnt_after", if_a.err_cnt, 2);

        // Two stop bits: good 0x81, then 0x3C with second stop bit low
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        s_dv = dv_b; s_se = se_b;
        send_frame(9'h081, 8, 1'b0, PAR_EVEN, 1'b0, 2, 2'b11);
        chk("2stop_good_pdata", if_b.P_DATA, 8'h81);
        chk("2stop_good_dv",    if_b.data_valid, 1);
        tick();
        s_dv = dv_b;
        send_frame(9'h03C, 8, 1'b0, PAR_EVEN, 1'b0, 2, 2'b01);
        chk("2stop_bad_stp_now", if_b.stp_err, 1);
        tick();
        chk("2stop_bad_stp_cnt", se_b - s_se, 1);
        chk("2stop_bad_dv_cnt",  dv_b - s_dv, 0);
        chk("2stop_bad_pdata",   if_b.P_DATA, 8'h81);
        chk("2stop_bad_errcnt",  if_b.err_cnt, 1);

        // 7O1 on the small instance; reset in the middle of DATA
        rst_c = 1'b1;
        tick();
        rst_c = 1'b0;
        send_frame(9'h02A, 7, 1'b1, PAR_ODD, 1'b0, 1, 2'b01);
        chk("7o1_pre_pdata", if_c.P_DATA, 7'h2A);
        tick();
        d55 = 9'h055;
        start_frame(1'b1, PAR_ODD);
        strobe(1'b0);
        for (int i = 0; i < 4; i++) strobe(d55[i]);
        chk("midrst_busy_before", if_c.busy, 1);
        rst_c = 1'b1;
        #1;
        chk("midrst_busy",   if_c.busy, 0);
        chk("midrst_pdata",  if_c.P_DATA, 0);
        chk("midrst_dv",     if_c.data_valid, 0);
        chk("midrst_errcnt", if_c.err_cnt, 0);
        tick();
        rst_c = 1'b0;
        s_dv = dv_c; s_pe = pe_c;
        send_frame(d55, 7, 1'b1, PAR_ODD, 1'b1, 1, 2'b01);
        chk("7o1_dv_now", if_c.data_valid, 1);
        chk("7o1_pdata",  if_c.P_DATA, 7'h55);
        tick();
        chk("7o1_dv_cnt", dv_c - s_dv, 1);
        chk("7o1_pe_cnt", pe_c - s_pe, 0);

        // 2-bit counter saturation, then clear coincident with an increment
        for (int i = 1; i <= 4; i++) begin
            start_frame(1'b0, PAR_EVEN);
            strobe(1'b1);
            chk($sformatf("sat_errcnt_%0d", i), if_c.err_cnt, (i < 3) ? i : 3);
        end
        start_frame(1'b0, PAR_EVEN);
        err_clr = 1'b1;
        strobe(1'b1);
        err_clr = 1'b0;
        chk("clr_glitch_pulse", if_c.strt_glitch, 1);
        chk("clr_errcnt",       if_c.err_cnt, 0);
        tick();
        chk("clr_errcnt_held",  if_c.err_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
